// File: rtl/cpu_pkg.sv
// Shared CPU definitions for the EX-stage divide sequencer and its divider.
package cpu_pkg;

  localparam int DATA_W      = 32;
  localparam int DIV_LATENCY = 35;

  typedef enum logic [2:0] {
    DIV_IDLE,
    DIV_ISSUE,
    DIV_WAIT,
    DIV_DONE,
    DIV_DRAIN
  } div_state_e;

  function automatic logic [DATA_W-1:0] absVal(input logic [DATA_W-1:0] v, input logic isSigned);
    return (isSigned && v[DATA_W-1]) ? -v : v;
  endfunction

endpackage

// File: rtl/div_issue_ctrl_div.sv
// Radix-2 restoring divider: one quotient bit per cycle on magnitudes, then a sign-fix cycle.
module div_issue_ctrl_div
  import cpu_pkg::*;
(
  input  logic              div_clk,
  input  logic              resetn,
  input  logic              div,
  input  logic              div_signed,
  input  logic [DATA_W-1:0] x,
  input  logic [DATA_W-1:0] y,
  output logic [DATA_W-1:0] s,
  output logic [DATA_W-1:0] r,
  output logic              complete
);

  localparam int CNT_W = 6;
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W);
  localparam logic [CNT_W-1:0] DONE_STEP = CNT_W'(DATA_W + 1);

  logic              busy_q, busy_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] quo_q, quo_d;
  logic [DATA_W-1:0] rem_q, rem_d;
  logic [DATA_W-1:0] den_q, den_d;
  logic              negQ_q, negQ_d;
  logic              negR_q, negR_d;
  logic [DATA_W-1:0] s_q, s_d;
  logic [DATA_W-1:0] r_q, r_d;

  logic [DATA_W:0]   shifted;
  logic              fits;
  logic [DATA_W-1:0] diff;

  assign shifted = {rem_q, quo_q[DATA_W-1]};
  assign fits    = shifted >= {1'b0, den_q};
  // When the trial subtraction fits, the true difference is below the divisor, so 32 bits suffice.
  assign diff    = shifted[DATA_W-1:0] - den_q;

  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    quo_d  = quo_q;
    rem_d  = rem_q;
    den_d  = den_q;
    negQ_d = negQ_q;
    negR_d = negR_q;
    s_d    = s_q;
    r_d    = r_q;
    if (busy_q) begin
      if (cnt_q < LAST_STEP) begin
        quo_d = {quo_q[DATA_W-2:0], fits};
        rem_d = fits ? diff : shifted[DATA_W-1:0];
      end else if (cnt_q == LAST_STEP) begin
        s_d = negQ_q ? -quo_q : quo_q;
        r_d = negR_q ? -rem_q : rem_q;
      end
      if (cnt_q == DONE_STEP) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end else if (div) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      quo_d  = absVal(x, div_signed);
      den_d  = absVal(y, div_signed);
      rem_d  = '0;
      negQ_d = div_signed & (x[DATA_W-1] ^ y[DATA_W-1]);
      negR_d = div_signed & x[DATA_W-1];
    end
  end

  always_ff @(posedge div_clk) begin
    if (!resetn) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      quo_q  <= '0;
      rem_q  <= '0;
      den_q  <= '0;
      negQ_q <= 1'b0;
      negR_q <= 1'b0;
      s_q    <= '0;
      r_q    <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      quo_q  <= quo_d;
      rem_q  <= rem_d;
      den_q  <= den_d;
      negQ_q <= negQ_d;
      negR_q <= negR_d;
      s_q    <= s_d;
      r_q    <= r_d;
    end
  end

  assign complete = busy_q && (cnt_q == DONE_STEP);
  assign s        = s_q;
  assign r        = r_q;

endmodule

// File: rtl/div_issue_ctrl.sv
// EX-stage DIV/DIVU sequencer: issues to the divider, stalls EX, writes HI/LO,
// and drains (never aborts) a divide cancelled by a WB flush.
module div_issue_ctrl
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              es_valid,
  input  logic              es_div_op,
  input  logic              es_div_signed,
  input  logic [DATA_W-1:0] es_src1,
  input  logic [DATA_W-1:0] es_src2,
  input  logic              es_flush,
  input  logic              ms_allowin,
  output logic              es_div_stall,
  output logic              hilo_we,
  output logic [DATA_W-1:0] hi_wdata,
  output logic [DATA_W-1:0] lo_wdata,
  output logic              div_busy
);

  div_state_e        state_q, state_d;
  logic [DATA_W-1:0] src1_q, src1_d;
  logic [DATA_W-1:0] src2_q, src2_d;
  logic              srcSigned_q, srcSigned_d;
  logic [DATA_W-1:0] hi_q, hi_d;
  logic [DATA_W-1:0] lo_q, lo_d;

  logic              request;
  logic              divStart;
  logic              divComplete;
  logic [DATA_W-1:0] divS;
  logic [DATA_W-1:0] divR;

  assign request = es_valid & es_div_op & ~es_flush;

  always_comb begin
    state_d     = state_q;
    src1_d      = src1_q;
    src2_d      = src2_q;
    srcSigned_d = srcSigned_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    divStart    = 1'b0;
    hilo_we     = 1'b0;
    unique case (state_q)
      DIV_IDLE: begin
        if (request) begin
          src1_d      = es_src1;
          src2_d      = es_src2;
          srcSigned_d = es_div_signed;
          state_d     = DIV_ISSUE;
        end
      end
      DIV_ISSUE: begin
        divStart = 1'b1;
        state_d  = es_flush ? DIV_DRAIN : DIV_WAIT;
      end
      DIV_WAIT: begin
        // A flush coinciding with completion has nothing left to drain.
        if (divComplete && es_flush) begin
          state_d = DIV_IDLE;
        end else if (divComplete) begin
          lo_d    = divS;
          hi_d    = divR;
          state_d = DIV_DONE;
        end else if (es_flush) begin
          state_d = DIV_DRAIN;
        end
      end
      DIV_DRAIN: begin
        if (divComplete) begin
          state_d = DIV_IDLE;
        end
      end
      DIV_DONE: begin
        hilo_we = ms_allowin & ~es_flush;
        if (ms_allowin || es_flush) begin
          state_d = DIV_IDLE;
        end
      end
      default: state_d = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= DIV_IDLE;
      src1_q      <= '0;
      src2_q      <= '0;
      srcSigned_q <= 1'b0;
      hi_q        <= '0;
      lo_q        <= '0;
    end else begin
      state_q     <= state_d;
      src1_q      <= src1_d;
      src2_q      <= src2_d;
      srcSigned_q <= srcSigned_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
    end
  end

  assign es_div_stall = es_valid & es_div_op & (state_q != DIV_DONE);
  assign div_busy     = (state_q != DIV_IDLE);
  assign hi_wdata     = hi_q;
  assign lo_wdata     = lo_q;

  div_issue_ctrl_div u_div (
    .div_clk    (clk),
    .resetn     (~reset),
    .div        (divStart),
    .div_signed (srcSigned_q),
    .x          (src1_q),
    .y          (src2_q),
    .s          (divS),
    .r          (divR),
    .complete   (divComplete)
  );

endmodule

// File: tb/tb_div_issue_ctrl.sv
// Bench for div_issue_ctrl: directed and random divides against an arithmetic reference
// with cycle-exact stall / write-strobe expectations.
module tb_div_issue_ctrl;

  localparam int WR_LAT    = 36;
  localparam int CUT_NONE  = 0;
  localparam int CUT_FLUSH = 1;
  localparam int CUT_RESET = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        es_valid;
  logic        es_div_op;
  logic        es_div_signed;
  logic [31:0] es_src1;
  logic [31:0] es_src2;
  logic        es_flush;
  logic        ms_allowin;
  logic        es_div_stall;
  logic        hilo_we;
  logic [31:0] hi_wdata;
  logic [31:0] lo_wdata;
  logic        div_busy;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;

  div_issue_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .es_valid      (es_valid),
    .es_div_op     (es_div_op),
    .es_div_signed (es_div_signed),
    .es_src1       (es_src1),
    .es_src2       (es_src2),
    .es_flush      (es_flush),
    .ms_allowin    (ms_allowin),
    .es_div_stall  (es_div_stall),
    .hilo_we       (hilo_we),
    .hi_wdata      (hi_wdata),
    .lo_wdata      (lo_wdata),
    .div_busy      (div_busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic applyStimulus(input bit v, input bit op, input bit sgn, input logic [31:0] a,
                               input logic [31:0] b, input bit fl, input bit al, input bit rst);
    es_valid      = v;
    es_div_op     = op;
    es_div_signed = sgn;
    es_src1       = a;
    es_src2       = b;
    es_flush      = fl;
    ms_allowin    = al;
    reset         = rst;
  endtask

  // Architectural result: truncating division, remainder takes the dividend's sign.
  function automatic void refDiv(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                                 output logic [31:0] q, output logic [31:0] r);
    int sa;
    int sb;
    sa = $signed(a);
    sb = $signed(b);
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000;
      r = 32'h0;
    end else if (sgn) begin
      q = sa / sb;
      r = sa % sb;
    end else begin
      q = a / b;
      r = a % b;
    end
  endfunction

  // Presents one divide from k=0; accepted at k=wait0, result held 'hold' cycles, optionally cut at k=cutAt.
  task automatic runDiv(input bit sgn, input logic [31:0] a, input logic [31:0] b,
                        input int wait0, input int hold, input int cutAt, input int cutKind);
    logic [31:0] expLo;
    logic [31:0] expHi;
    int doneAt;
    int wrAt;
    bit cutNow;
    refDiv(sgn, a, b, expLo, expHi);
    doneAt = wait0 + WR_LAT;
    wrAt   = doneAt + hold;
    for (int k = 0; k <= wrAt; k++) begin
      cutNow = (cutKind != CUT_NONE) && (k == cutAt);
      applyStimulus(1'b1, 1'b1, sgn, a, b, cutNow && cutKind == CUT_FLUSH,
                    !(k >= doneAt && k < wrAt), cutNow && cutKind == CUT_RESET);
      @(negedge clk);
      checkOutput("stall", {31'b0, es_div_stall}, {31'b0, k < doneAt});
      checkOutput("hilo_we", {31'b0, hilo_we}, {31'b0, cutKind == CUT_NONE && k == wrAt});
      if (k == wait0) checkOutput("busy_accept", {31'b0, div_busy}, 32'd0);
      if (k == wait0 + 10) checkOutput("busy_wait", {31'b0, div_busy}, 32'd1);
      if (cutKind == CUT_NONE && k >= doneAt) begin
        checkOutput("lo", lo_wdata, expLo);
        checkOutput("hi", hi_wdata, expHi);
      end
      @(posedge clk);
      #1;
      if (cutNow) break;
    end
  endtask

  initial begin
    logic [31:0] ra;
    logic [31:0] rb;
    bit rs;

    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b1);
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_busy", {31'b0, div_busy}, 32'd0);
    checkOutput("rst_we", {31'b0, hilo_we}, 32'd0);
    checkOutput("rst_hi", hi_wdata, 32'd0);
    checkOutput("rst_lo", lo_wdata, 32'd0);
    checkOutput("rst_stall", {31'b0, es_div_stall}, 32'd0);
    @(posedge clk);
    #1;

    applyStimulus(1'b1, 1'b0, 1'b0, 32'd5, 32'd1, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("nondiv_stall", {31'b0, es_div_stall}, 32'd0);
    @(posedge clk);
    #1;
    applyStimulus(1'b1, 1'b1, 1'b1, 32'd5, 32'd1, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("nondiv_busy", {31'b0, div_busy}, 32'd0);
    checkOutput("flush_idle_stall", {31'b0, es_div_stall}, 32'd1);
    @(posedge clk);
    #1;
    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("flush_idle_busy", {31'b0, div_busy}, 32'd0);
    @(posedge clk);
    #1;

    runDiv(1'b1, 32'd100, 32'd7, 0, 0, 0, CUT_NONE);
    runDiv(1'b1, 32'hFFFF_FFF9, 32'd2, 0, 0, 0, CUT_NONE);
    runDiv(1'b1, 32'd7, 32'hFFFF_FFFE, 0, 0, 0, CUT_NONE);
    runDiv(1'b0, 32'hFFFF_FFFF, 32'd1, 0, 0, 0, CUT_NONE);
    runDiv(1'b0, 32'h8000_0000, 32'd3, 0, 0, 0, CUT_NONE);

    runDiv(1'b1, 32'd1234, 32'd5, 0, 0, 10, CUT_FLUSH);
    runDiv(1'b0, 32'd20, 32'd6, 25, 0, 0, CUT_NONE);

    runDiv(1'b1, 32'hDEAD_BEEF, 32'd77, 0, 5, 0, CUT_NONE);

    runDiv(1'b0, 32'd999, 32'd4, 0, 0, 1, CUT_FLUSH);
    runDiv(1'b0, 32'd1000, 32'd7, 34, 0, 0, CUT_NONE);

    runDiv(1'b1, 32'd555, 32'd11, 0, 0, 35, CUT_FLUSH);
    runDiv(1'b0, 32'd81, 32'd9, 0, 0, 0, CUT_NONE);

    runDiv(1'b1, 32'd4242, 32'd13, 0, 0, 36, CUT_FLUSH);
    runDiv(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, CUT_NONE);

    runDiv(1'b1, 32'd31337, 32'd10, 0, 0, 20, CUT_RESET);
    runDiv(1'b1, 32'd9, 32'd3, 0, 0, 0, CUT_NONE);

    for (int i = 0; i < 8; i++) begin
      rs = 1'($urandom_range(0, 1));
      ra = $urandom;
      rb = $urandom_range(0, 1) ? $urandom : 32'($urandom_range(1, 1000));
      if (rb == 32'd0) rb = 32'd1;
      runDiv(rs, ra, rb, 0, $urandom_range(0, 3), 0, CUT_NONE);
    end

    applyStimulus(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("idle_we", {31'b0, hilo_we}, 32'd0);
      checkOutput("idle_busy", {31'b0, div_busy}, 32'd0);
      @(posedge clk);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
